// File: rtl/sysid_read_arbiter_pkg.sv
// sysid_arb_pkg: shared types and constants for the system-ID read arbiter.
//   state_e          - arbiter FSM states
//   DATA_W           - slave/requester read data width
//   STAT_W           - per-requester grant counter width (SYSID_ARB_STATS_EN)
//   MAX_READ_LATENCY - largest supported slave read latency
package sysid_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam int DATA_W           = 32;
    localparam int STAT_W           = 16;
    localparam int MAX_READ_LATENCY = 7;
endpackage

// File: rtl/sysid_read_arbiter_if.sv
// sysid_read_arbiter_if: requester-side Avalon-MM read ports plus the shared
// slave read port, bundled for the arbiter.
//   slave  modport - arbiter view (accepts requester reads, drives the slave)
//   master modport - environment view (requesters and the slave itself)
//   m_read/m_address       requester read strobes, addresses (slice i = req i)
//   m_waitrequest          per-requester accept (low = accepted)
//   m_readdata/m_readdatavalid  shared return data, one-hot valid pulse
//   s_read/s_address/s_readdata slave read port
interface sysid_read_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 1
);
    import sysid_arb_pkg::*;

    logic [NUM_REQ-1:0]        m_read;
    logic [NUM_REQ*ADDR_W-1:0] m_address;
    logic [NUM_REQ-1:0]        m_waitrequest;
    logic [DATA_W-1:0]         m_readdata;
    logic [NUM_REQ-1:0]        m_readdatavalid;
    logic                      s_read;
    logic [ADDR_W-1:0]         s_address;
    logic [DATA_W-1:0]         s_readdata;

    modport slave (
        input  m_read, m_address, s_readdata,
        output m_waitrequest, m_readdata, m_readdatavalid, s_read, s_address
    );

    modport master (
        output m_read, m_address, s_readdata,
        input  m_waitrequest, m_readdata, m_readdatavalid, s_read, s_address
    );
endinterface

// File: rtl/sysid_read_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
//   req_i - request vector
//   ptr_i - index holding highest priority; priority then ascends with wrap
//   gnt_o - one-hot grant (zero when no request)
//   idx_o - encoded index of the granted request
module rr_pick #(
    parameter  int N     = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);
    // Walk from lowest priority to highest so the last hit is the winner.
    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                gnt_o    = '0;
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/sysid_read_arbiter.sv
// sysid_read_arbiter: round-robin arbiter sharing one read-only Avalon-MM
// slave between NUM_REQ requesters, one outstanding read at a time.
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   bus (slave)   - requester read ports and slave read port
//   stat_grants   - per-requester saturating grant counters (SYSID_ARB_STATS_EN)
//   stat_clear    - synchronous clear of all grant counters (SYSID_ARB_STATS_EN)
// Optional feature macro: SYSID_ARB_STATS_EN.
module sysid_read_arbiter
    import sysid_arb_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int ADDR_W       = 1,
    parameter int READ_LATENCY = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    sysid_read_arbiter_if.slave       bus
`ifdef SYSID_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] stat_grants,
    input  logic                      stat_clear
`endif
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 3;

    if (READ_LATENCY > MAX_READ_LATENCY || READ_LATENCY < 0) begin : g_bad_lat
        $error("READ_LATENCY out of range");
    end

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic [ADDR_W-1:0]  pick_addr;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i (bus.m_read),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // One-hot grant selects the winner's address slice.
    always_comb begin
        pick_addr = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick_gnt[i]) pick_addr = pick_addr | bus.m_address[i*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;

        bus.m_waitrequest   = '1;
        bus.m_readdatavalid = '0;
        bus.m_readdata      = data_q;  // holds last returned value
        bus.s_read          = 1'b0;
        bus.s_address       = '0;

        case (state_q)
            IDLE: begin
                if (|bus.m_read) begin
                    win_d   = pick_idx;
                    addr_d  = pick_addr;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.s_read               = 1'b1;
                bus.s_address            = addr_q;
                bus.m_waitrequest[win_q] = 1'b0;
                if (READ_LATENCY == 0) begin
                    data_d  = bus.s_readdata;
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = bus.s_readdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                bus.m_readdatavalid[win_q] = 1'b1;
                ptr_d   = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SYSID_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] grants_q;

    // Clear has priority over the RESP-cycle increment.
    always_ff @(posedge clock) begin
        if (reset || stat_clear)
            grants_q <= '0;
        else if (state_q == RESP && grants_q[win_q] != '1)
            grants_q[win_q] <= grants_q[win_q] + 1'b1;
    end

    assign stat_grants = grants_q;
`endif
endmodule

// File: doc/sysid_read_arbiter.md
Name: sysid_read_arbiter

Overview:
- Round-robin read arbiter that shares one read-only Avalon-MM control slave (e.g. the system-ID slave) between NUM_REQ requesters, such as the Nios core, the VME/config bridge and the boot checker.
- Issues one slave read at a time and returns the data to the granted requester with a single-cycle readdatavalid pulse.
- Sits between the requester-side Avalon-MM read ports and the slave's address/readdata port.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 1, slave address width.
- READ_LATENCY, 0, slave cycles from s_read to valid s_readdata (0 = combinational slave, max 7).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- m_read  input  NUM_REQ  per-requester read request; held until accepted.
- m_address  input  NUM_REQ*ADDR_W  per-requester address, slice i = requester i.
- m_waitrequest  output  NUM_REQ  per-requester; low only in that requester's accept cycle.
- m_readdata  output  32  shared return data, qualified by m_readdatavalid.
- m_readdatavalid  output  NUM_REQ  one-hot, one-cycle data-valid pulse.
- s_read  output  1  read strobe to slave.
- s_address  output  ADDR_W  address to slave.
- s_readdata  input  32  slave read data.

Behaviour:
- Reset values:
  - s_read=0, s_address=0, m_readdata=0, m_readdatavalid=0, m_waitrequest=all 1.
  - state=IDLE, rr_ptr=0, latency counter=0.
- State machine IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
  - IDLE: if any m_read, pick the winner by round-robin starting at rr_ptr (rr_ptr has highest priority, then ascending with wrap). Register winner and its address, go to ISSUE. With no requests, stay in IDLE.
  - ISSUE (1 cycle): s_read=1, s_address=latched address, m_waitrequest[winner]=0. If READ_LATENCY=0, capture s_readdata and go to RESP; else load the counter with READ_LATENCY-1 and go to WAIT.
  - WAIT: decrement the counter. At 0, capture s_readdata and go to RESP. s_read=0 throughout WAIT.
  - RESP (1 cycle): m_readdata=captured data, m_readdatavalid[winner]=1, rr_ptr=(winner+1) mod NUM_REQ, go to IDLE.
- Latency from m_read rising in IDLE to m_readdatavalid: 2+READ_LATENCY cycles.
- Throughput: one read per 3+READ_LATENCY cycles. Only one read is outstanding at a time.
- Requests arriving outside IDLE are not sampled. Those requesters keep waitrequest high.
- Losing requesters in IDLE keep waitrequest high and are re-arbitrated next IDLE.
- If the winner drops m_read before ISSUE (protocol violation), the read still completes and readdatavalid still pulses.
- m_readdata holds its last value between RESP cycles.
- Simultaneous requests from all requesters are served in order rr_ptr, rr_ptr+1, ... with no starvation. Maximum wait is NUM_REQ*(3+READ_LATENCY) cycles.
- Reset asserted mid-operation: next edge forces the reset values. The in-flight read is discarded and no readdatavalid is issued.

Optional Feature:
- Macro SYSID_ARB_STATS_EN.
- When defined:
  - Adds output stat_grants (NUM_REQ*16).
  - Per-requester 16-bit grant counters increment in that requester's RESP cycle and saturate at 0xFFFF.
  - Input stat_clear (1 bit) zeroes all counters synchronously; clear wins over a simultaneous increment.
  - Counters reset to 0.
- When undefined: neither port nor counters exist, and the remaining behaviour is identical.

Decomposition:
- Package sysid_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP}
  - DATA_W=32
  - STAT_W=16
  - MAX_READ_LATENCY=7
- Sub-module rr_pick is a combinational round-robin priority selector: req vector plus ptr in, one-hot grant plus encoded index out. It is reused by other arbiters.

Test Plan:
- Single request, READ_LATENCY=0: m_read[1]=1, address=1, slave returns 0x557AE8EA. Expect waitrequest[1] low at cycle 1, readdatavalid[1] at cycle 2 with m_readdata=0x557AE8EA, rr_ptr=2.
- All three requesters held, addresses 0/1/0: grants in order 0,1,2 with readdatavalid at cycles 2, 5, 8. Data alternates 0x00475450 / 0x557AE8EA / 0x00475450.
- READ_LATENCY=3: one request. Expect s_read high for exactly 1 cycle, readdatavalid 5 cycles after the request, and no extra s_read pulses.
- Reset asserted during WAIT: no readdatavalid. All outputs at reset values next cycle. The request after reset is granted to requester 0 first.
- Protocol violation: winner drops m_read after IDLE. A readdatavalid pulse still occurs and the next grant goes to winner+1.
- SYSID_ARB_STATS_EN: 70000 grants to requester 0 saturate stat_grants[0] at 0xFFFF. stat_clear in a RESP cycle yields 0.
